// File: rtl/pwm_fader.sv
// pwm_fader: eight-channel duty ramp sequencer sharing one add/compare unit across a per-tick scan.
module pwm_fader #(
  parameter int CNTR_BITS = 8,
  parameter int STEP_DIV  = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_ch,
  input  logic [CNTR_BITS-1:0] cmd_target,
  input  logic [CNTR_BITS-1:0] cmd_step,
  output logic [CNTR_BITS-1:0] duty0,
  output logic [CNTR_BITS-1:0] duty1,
  output logic [CNTR_BITS-1:0] duty2,
  output logic [CNTR_BITS-1:0] duty3,
  output logic [CNTR_BITS-1:0] duty4,
  output logic [CNTR_BITS-1:0] duty5,
  output logic [CNTR_BITS-1:0] duty6,
  output logic [CNTR_BITS-1:0] duty7,
  output logic [7:0]           busy,
  output logic [7:0]           done
);
  localparam int CW = $clog2(STEP_DIV);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic tick, accept, up;
  logic [CNTR_BITS-1:0] cur [8];
  logic [CNTR_BITS-1:0] tgt [8];
  logic [CNTR_BITS-1:0] stp [8];
  logic [CNTR_BITS-1:0] c, t, s, diff, nxt;
  assign tick = cnt == CW'(STEP_DIV - 1);
  assign cmd_ready = state == IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign {duty7, duty6, duty5, duty4, duty3, duty2, duty1, duty0} =
    {cur[7], cur[6], cur[5], cur[4], cur[3], cur[2], cur[1], cur[0]};
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (tick ? SCAN : IDLE) : (idx == 3'd7 ? IDLE : SCAN);
  end
  // Differences are taken toward the target so a step can never overshoot or wrap.
  always_comb begin
    c = cur[idx];
    t = tgt[idx];
    s = stp[idx];
    up = c < t;
    diff = up ? t - c : c - t;
    nxt = (s == '0 || diff <= s) ? t : (up ? c + s : c - s);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      busy <= '0;
      done <= '0;
      for (int i = 0; i < 8; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
        stp[i] <= '0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      idx <= state == SCAN ? idx + 3'd1 : 3'd0;
      done <= '0;
      if (accept) begin
        tgt[cmd_ch] <= cmd_target;
        stp[cmd_ch] <= cmd_step;
        busy[cmd_ch] <= cmd_target != cur[cmd_ch];
      end
      if (state == SCAN && c != t) begin
        cur[idx] <= nxt;
        if (nxt == t) begin
          busy[idx] <= 1'b0;
          done[idx] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed checks of ramping, clamping, retarget, backpressure and reset.
module tb_pwm_fader;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic cmd_ready;
  logic [2:0] cmd_ch = 0;
  logic [7:0] cmd_target = 0, cmd_step = 0;
  logic [7:0] d [8];
  logic [7:0] busy, done;
  int n_cmp = 0, n_bad = 0;
  int done_cnt [8];
  int n;
  pwm_fader #(.CNTR_BITS(8), .STEP_DIV(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .duty0(d[0]), .duty1(d[1]), .duty2(d[2]), .duty3(d[3]),
    .duty4(d[4]), .duty5(d[5]), .duty6(d[6]), .duty7(d[7]),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 8; i++) done_cnt[i] = 0;
  always @(negedge clk)
    for (int i = 0; i < 8; i++) if (done[i]) done_cnt[i]++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_scan();
    int k = 0, low = 0;
    while (cmd_ready && k < 30) begin @(negedge clk); k++; end
    while (!cmd_ready && low < 30) begin @(negedge clk); low++; end
    chk("scan_len", low, 8);
  endtask
  task automatic send(input int ch, input int tg, input int st);
    int k = 0;
    while (!cmd_ready && k < 30) begin @(negedge clk); k++; end
    chk("send_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_ch = 3'(ch); cmd_target = 8'(tg); cmd_step = 8'(st);
    @(posedge clk); #1 cmd_valid = 0;
  endtask
  task automatic tick_gap();
    n = 0;
    do begin @(negedge clk); n++; end while (cmd_ready && n < 30);
    chk("tick_restart", n, 10);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_duty2", d[2], 0);
    rst = 0;
    tick_gap();
    repeat (3) wait_scan();
    for (int i = 0; i < 8; i++) chk($sformatf("idle_duty%0d", i), d[i], 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done_cnt[0] + done_cnt[2] + done_cnt[7], 0);
    // ch2 ramps up in steps of 50
    send(2, 200, 50);
    @(negedge clk);
    chk("acc_busy2", busy, 8'h04);
    chk("acc_duty2", d[2], 0);
    wait_scan(); chk("ramp2_a", d[2], 50);
    wait_scan(); chk("ramp2_b", d[2], 100);
    wait_scan(); chk("ramp2_c", d[2], 150);
    chk("ramp2_busy", busy, 8'h04);
    chk("ramp2_nodone", done_cnt[2], 0);
    wait_scan(); chk("ramp2_d", d[2], 200);
    chk("ramp2_busy_clr", busy, 0);
    chk("ramp2_done", done_cnt[2], 1);
    chk("ramp2_other", d[3], 0);
    // ch5 jumps to 200, then descends with clamping at the target
    send(5, 200, 0);
    @(negedge clk); wait_scan();
    chk("jump5", d[5], 200);
    chk("jump5_done", done_cnt[5], 1);
    send(5, 5, 64);
    @(negedge clk); wait_scan(); chk("down5_a", d[5], 136);
    wait_scan(); chk("down5_b", d[5], 72);
    wait_scan(); chk("down5_c", d[5], 8);
    chk("down5_nodone", done_cnt[5], 1);
    wait_scan(); chk("down5_d", d[5], 5);
    chk("down5_done", done_cnt[5], 2);
    send(0, 255, 0);
    @(negedge clk); wait_scan();
    chk("jump0", d[0], 255);
    chk("jump0_done", done_cnt[0], 1);
    // command held during SCAN waits for IDLE
    n = 0;
    while (cmd_ready && n < 30) begin @(negedge clk); n++; end
    cmd_valid = 1; cmd_ch = 3'd1; cmd_target = 8'd40; cmd_step = 8'd0;
    n = 1;
    @(negedge clk);
    while (!cmd_ready && n < 30) begin
      chk("hold_not_acc", busy[1], 0);
      @(negedge clk); n++;
    end
    chk("hold_low_cycles", n, 8);
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    chk("hold_busy1", busy[1], 1);
    chk("hold_duty1", d[1], 0);
    wait_scan(); chk("hold_jump1", d[1], 40);
    // ch3 retargeted mid-ramp
    send(3, 240, 16);
    @(negedge clk); wait_scan(); chk("rt3_a", d[3], 16);
    wait_scan(); chk("rt3_b", d[3], 32);
    wait_scan(); chk("rt3_c", d[3], 48);
    send(3, 32, 16);
    @(negedge clk); wait_scan(); chk("rt3_d", d[3], 32);
    chk("rt3_busy", busy[3], 0);
    wait_scan(); chk("rt3_hold", d[3], 32);
    chk("rt3_done", done_cnt[3], 1);
    // reset in the fourth SCAN cycle with three ramps pending
    send(4, 200, 1);
    send(6, 200, 1);
    send(7, 200, 1);
    @(negedge clk);
    chk("pre_rst_busy", busy, 8'hD0);
    n = 0;
    while (cmd_ready && n < 30) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_duty4", d[4], 0);
    chk("mid_rst_duty7", d[7], 0);
    chk("mid_rst_duty2", d[2], 0);
    rst = 0;
    tick_gap();
    wait_scan();
    chk("post_rst_duty6", d[6], 0);
    chk("post_rst_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
